// File: rtl/cwt_mem_pkg.sv
// Shared constants and pointer arithmetic for the CWT sample buffers.
package cwt_mem_pkg;

  localparam int DEFAULT_BITS         = 16;
  localparam int DEFAULT_ADDRESS_BITS = 4;

  // Circular (base - lag) mod depth. The result is only meaningful for
  // lag <= base + depth; callers flag larger lags as misses.
  function automatic int unsigned mod_sub(input int unsigned base,
                                          input int unsigned lag,
                                          input int unsigned depth);
    if (base >= lag) return base - lag;
    return base + depth - lag;
  endfunction

endpackage

// File: rtl/cwt_sample_buffer_rdport.sv
// One read channel of the CWT sample buffer: lag-to-address translation,
// miss test and the registered response.
module cwt_sample_buffer_rdport
  import cwt_mem_pkg::*;
#(
  parameter int BITS                = DEFAULT_BITS,
  parameter int ADDRESS_BITS        = DEFAULT_ADDRESS_BITS,
  parameter int NUMBER_OF_LOCATIONS = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                enable,
  input  logic [ADDRESS_BITS-1:0]             offset,
  input  logic [ADDRESS_BITS-1:0]             base_pointer,
  input  logic [ADDRESS_BITS:0]               valid_count,
  input  logic                                bypass,
  input  logic [BITS-1:0]                     bypass_data,
  input  logic                                force_miss,
  input  logic [NUMBER_OF_LOCATIONS*BITS-1:0] memory,
  output logic [BITS-1:0]                     data,
  output logic                                valid,
  output logic                                miss
);

  logic [ADDRESS_BITS-1:0] address;
  logic [31:0]             lag;
  logic                    lookup_miss;
  logic [BITS-1:0]         lookup_data;

  // Without bypass the newest sample sits one behind the write pointer;
  // with bypass the incoming sample occupies the write pointer itself.
  always_comb begin
    lag         = 32'(offset) + (bypass ? 32'd0 : 32'd1);
    address     = ADDRESS_BITS'(mod_sub(32'(base_pointer), lag, 32'(NUMBER_OF_LOCATIONS)));
    lookup_miss = force_miss
                | ({1'b0, offset} >= valid_count)
                | (32'(offset) >= 32'(NUMBER_OF_LOCATIONS));
    lookup_data = '0;
    if (!lookup_miss) begin
      if (bypass && offset == '0) lookup_data = bypass_data;
      else                        lookup_data = memory[address*BITS +: BITS];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data  <= '0;
      valid <= 1'b0;
      miss  <= 1'b0;
    end else begin
      valid <= enable;
      if (enable) begin
        data <= lookup_data;
        miss <= lookup_miss;
      end
    end
  end

endmodule

// File: rtl/cwt_sample_buffer.sv
// Multi-port circular sample buffer addressed by lag from the newest sample.
// Build option: define READ_BYPASS_EN to make same-cycle reads see the write.
module cwt_sample_buffer
  import cwt_mem_pkg::*;
#(
  parameter int BITS                = DEFAULT_BITS,
  parameter int ADDRESS_BITS        = DEFAULT_ADDRESS_BITS,
  parameter int NUMBER_OF_LOCATIONS = 16,
  parameter int READ_PORTS          = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               clear,
  input  logic                               write_enable,
  input  logic [BITS-1:0]                    write_data,
  output logic [ADDRESS_BITS-1:0]            write_address,
  output logic [ADDRESS_BITS:0]              fill_count,
  output logic                               full,
  input  logic [READ_PORTS-1:0]              read_enable,
  input  logic [READ_PORTS*ADDRESS_BITS-1:0] read_offset,
  output logic [READ_PORTS*BITS-1:0]         read_data,
  output logic [READ_PORTS-1:0]              read_valid,
  output logic [READ_PORTS-1:0]              read_miss
);

  // Read handshake: read_enable[p] is always accepted; read_valid[p] pulses
  // for exactly one cycle on the following cycle, with read_data/read_miss.

  localparam logic [ADDRESS_BITS-1:0] LAST_ADDRESS = ADDRESS_BITS'(NUMBER_OF_LOCATIONS - 1);
  localparam logic [ADDRESS_BITS:0]   DEPTH        = (ADDRESS_BITS+1)'(NUMBER_OF_LOCATIONS);

  logic [BITS-1:0]                     mem_q [NUMBER_OF_LOCATIONS];
  logic [NUMBER_OF_LOCATIONS*BITS-1:0] mem_flat;
  logic [ADDRESS_BITS-1:0]             wp_q, wp_next;
  logic [ADDRESS_BITS:0]               count_q, count_next;
  logic                                do_write;
  logic                                bypass;
  logic [ADDRESS_BITS:0]               read_count;

  assign do_write   = write_enable & ~clear;
  assign wp_next    = (wp_q == LAST_ADDRESS) ? '0 : wp_q + 1'b1;
  assign count_next = (count_q == DEPTH) ? count_q : count_q + 1'b1;

`ifdef READ_BYPASS_EN
  assign bypass     = do_write;
  assign read_count = do_write ? count_next : count_q;
`else
  assign bypass     = 1'b0;
  assign read_count = count_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < NUMBER_OF_LOCATIONS; i++) mem_q[i] <= '0;
    end else if (clear) begin
      wp_q    <= '0;
      count_q <= '0;
    end else if (write_enable) begin
      mem_q[wp_q] <= write_data;
      wp_q        <= wp_next;
      count_q     <= count_next;
    end
  end

  for (genvar i = 0; i < NUMBER_OF_LOCATIONS; i++) begin : g_flat
    assign mem_flat[i*BITS +: BITS] = mem_q[i];
  end

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
    cwt_sample_buffer_rdport #(
      .BITS                (BITS),
      .ADDRESS_BITS        (ADDRESS_BITS),
      .NUMBER_OF_LOCATIONS (NUMBER_OF_LOCATIONS)
    ) u_rdport (
      .clk          (clk),
      .rst          (rst),
      .enable       (read_enable[p]),
      .offset       (read_offset[p*ADDRESS_BITS +: ADDRESS_BITS]),
      .base_pointer (wp_q),
      .valid_count  (read_count),
      .bypass       (bypass),
      .bypass_data  (write_data),
      .force_miss   (clear),
      .memory       (mem_flat),
      .data         (read_data[p*BITS +: BITS]),
      .valid        (read_valid[p]),
      .miss         (read_miss[p])
    );
  end

  assign write_address = wp_q;
  assign fill_count    = count_q;
  assign full          = (count_q == DEPTH);

endmodule

// File: tb/tb_cwt_sample_buffer.sv
// Directed plus randomized check of cwt_sample_buffer with a per-port
// expected-response queue.
module tb_cwt_sample_buffer;

  localparam int BITS = 16;
  localparam int AB   = 4;
  localparam int N    = 16;
  localparam int RP   = 2;

  localparam logic [BITS:0] MISS_RSP = {1'b1, 16'd0};
`ifdef READ_BYPASS_EN
  localparam logic [BITS:0] SIM_P0 = {1'b0, 16'd99};
  localparam logic [BITS:0] SIM_P1 = {1'b0, 16'd6};
`else
  localparam logic [BITS:0] SIM_P0 = {1'b0, 16'd20};
  localparam logic [BITS:0] SIM_P1 = {1'b0, 16'd5};
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               clear = 1'b0;
  logic               write_enable = 1'b0;
  logic [BITS-1:0]    write_data = '0;
  logic [AB-1:0]      write_address;
  logic [AB:0]        fill_count;
  logic               full;
  logic [RP-1:0]      read_enable = '0;
  logic [RP*AB-1:0]   read_offset = '0;
  logic [RP*BITS-1:0] read_data;
  logic [RP-1:0]      read_valid;
  logic [RP-1:0]      read_miss;

  int total = 0;
  int bad   = 0;

  logic [BITS:0] exp_q0[$];
  logic [BITS:0] exp_q1[$];

  logic [BITS-1:0] m_mem [N];
  int              m_wp;
  int              m_cnt;

  cwt_sample_buffer #(
    .BITS                (BITS),
    .ADDRESS_BITS        (AB),
    .NUMBER_OF_LOCATIONS (N),
    .READ_PORTS          (RP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .clear         (clear),
    .write_enable  (write_enable),
    .write_data    (write_data),
    .write_address (write_address),
    .fill_count    (fill_count),
    .full          (full),
    .read_enable   (read_enable),
    .read_offset   (read_offset),
    .read_data     (read_data),
    .read_valid    (read_valid),
    .read_miss     (read_miss)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input int wa, input int fc, input logic fl);
    check("write_address", 32'(write_address), 32'(wa));
    check("fill_count", 32'(fill_count), 32'(fc));
    check("full", 32'(full), 32'(fl));
  endtask

  // Drive one cycle; expectations enter the queues with the request and are
  // retired when the matching read_valid shows up one edge later.
  task automatic step(input logic we, input logic [BITS-1:0] wd, input logic clr,
                      input logic [1:0] re, input logic [AB-1:0] o0, input logic [AB-1:0] o1,
                      input logic [BITS:0] e0, input logic [BITS:0] e1);
    logic [BITS:0] e;
    write_enable = we;
    write_data   = wd;
    clear        = clr;
    read_enable  = re;
    read_offset  = {o1, o0};
    if (re[0]) exp_q0.push_back(e0);
    if (re[1]) exp_q1.push_back(e1);
    @(posedge clk);
    #1;
    write_enable = 1'b0;
    clear        = 1'b0;
    read_enable  = '0;
    check("read_valid", 32'(read_valid), 32'(re));
    if (read_valid[0]) begin
      e = (exp_q0.size() > 0) ? exp_q0.pop_front() : 'x;
      check("port0_rsp", 32'({read_miss[0], read_data[15:0]}), 32'(e));
    end
    if (read_valid[1]) begin
      e = (exp_q1.size() > 0) ? exp_q1.pop_front() : 'x;
      check("port1_rsp", 32'({read_miss[1], read_data[31:16]}), 32'(e));
    end
  endtask

  function automatic logic [BITS:0] model_rsp(input int off);
    if (off >= m_cnt) return MISS_RSP;
    return {1'b0, m_mem[(m_wp + N - 1 - off) % N]};
  endfunction

  initial begin
    logic [BITS-1:0] d;
    logic [AB-1:0]   o0, o1;
    logic [1:0]      re;

    // reset state
    #12;
    check("rst_data", 32'(read_data), 32'd0);
    check("rst_valid_miss", 32'({read_valid, read_miss}), 32'd0);
    check_state(0, 0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // basic write/read
    step(1'b1, 16'd10, 1'b0, 2'b00, 4'd0, 4'd0, '0, '0);
    check_state(1, 1, 1'b0);
    step(1'b1, 16'd20, 1'b0, 2'b00, 4'd0, 4'd0, '0, '0);
    step(1'b1, 16'd30, 1'b0, 2'b00, 4'd0, 4'd0, '0, '0);
    check_state(3, 3, 1'b0);
    step(1'b0, 16'd0, 1'b0, 2'b11, 4'd0, 4'd2, {1'b0, 16'd30}, {1'b0, 16'd10});
    check_state(3, 3, 1'b0);

    // miss: offset equal to fill_count and beyond
    step(1'b0, 16'd0, 1'b0, 2'b11, 4'd3, 4'd15, MISS_RSP, MISS_RSP);
    step(1'b0, 16'd0, 1'b0, 2'b01, 4'd1, 4'd0, {1'b0, 16'd20}, '0);
    // idle cycle: valid drops, data holds
    step(1'b0, 16'd0, 1'b0, 2'b00, 4'd0, 4'd0, '0, '0);
    check("hold_data", 32'(read_data), {16'd0, 16'd20});

    // asynchronous reset mid-cycle with reads pending
    read_enable = 2'b11;
    write_enable = 1'b1;
    write_data = 16'd123;
    #3;
    rst = 1'b0;
    #1;
    check("midrst_data", 32'(read_data), 32'd0);
    check("midrst_valid_miss", 32'({read_valid, read_miss}), 32'd0);
    check_state(0, 0, 1'b0);
    @(posedge clk);
    #1;
    check("midrst_no_rsp", 32'(read_valid), 32'd0);
    read_enable = '0;
    write_enable = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_state(0, 0, 1'b0);

    // wrap: 20 writes into 16 locations
    for (int i = 1; i <= 20; i++) step(1'b1, BITS'(i), 1'b0, 2'b00, 4'd0, 4'd0, '0, '0);
    check_state(4, 16, 1'b1);
    step(1'b0, 16'd0, 1'b0, 2'b11, 4'd0, 4'd15, {1'b0, 16'd20}, {1'b0, 16'd5});

    // simultaneous read and write
    step(1'b1, 16'd99, 1'b0, 2'b11, 4'd0, 4'd15, SIM_P0, SIM_P1);
    check_state(5, 16, 1'b1);
    step(1'b0, 16'd0, 1'b0, 2'b11, 4'd0, 4'd1, {1'b0, 16'd99}, {1'b0, 16'd20});

    // clear beats write; reads in that cycle miss
    step(1'b1, 16'd77, 1'b1, 2'b11, 4'd0, 4'd1, MISS_RSP, MISS_RSP);
    check_state(0, 0, 1'b0);
    step(1'b1, 16'd55, 1'b0, 2'b00, 4'd0, 4'd0, '0, '0);
    check_state(1, 1, 1'b0);
    step(1'b0, 16'd0, 1'b0, 2'b11, 4'd0, 4'd1, {1'b0, 16'd55}, MISS_RSP);

    // randomized traffic against a reference model, starting from a clear
    step(1'b0, 16'd0, 1'b1, 2'b00, 4'd0, 4'd0, '0, '0);
    m_wp  = 0;
    m_cnt = 0;
    for (int i = 0; i < N; i++) m_mem[i] = '0;
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        d = BITS'($urandom_range(0, 65535));
        step(1'b1, d, 1'b0, 2'b00, 4'd0, 4'd0, '0, '0);
        m_mem[m_wp] = d;
        m_wp  = (m_wp + 1) % N;
        m_cnt = (m_cnt < N) ? m_cnt + 1 : N;
      end else begin
        o0 = AB'($urandom_range(0, N - 1));
        o1 = (it % 4 == 0) ? o0 : AB'($urandom_range(0, N - 1));
        re = 2'($urandom_range(1, 3));
        step(1'b0, 16'd0, 1'b0, re, o0, o1, model_rsp(int'(o0)), model_rsp(int'(o1)));
      end
      check("rand_fill_count", 32'(fill_count), 32'(m_cnt));
      check("rand_write_address", 32'(write_address), 32'(m_wp));
    end

    check("queues_drained", 32'(exp_q0.size() + exp_q1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
